// File: rtl/weave_pkg.sv
// weave_pkg: shared opcodes, controller states and small helpers for the
// weave pattern sequencer.
package weave_pkg;

    localparam int ROWS_MAX  = 8;
    localparam int ROW_IDX_W = 3;

    typedef enum logic [1:0] {
        LOAD_ROW   = 2'd0,
        SET_PERIOD = 2'd1,
        START      = 2'd2,
        STOP       = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } seq_state_e;

    // Next playback row: after the programmed last row, wrap back to row 0.
    function automatic logic [ROW_IDX_W-1:0] next_row(
        input logic [ROW_IDX_W-1:0] row,
        input logic [ROW_IDX_W-1:0] last
    );
        return (row == last) ? '0 : row + 1'b1;
    endfunction

endpackage

// File: rtl/weave_row_mem.sv
// weave_row_mem: ROWS x WIDTH flop array holding the weave rows.
// One synchronous write port, one combinational read port. A read of the
// row being written in the same cycle returns the old contents.
module weave_row_mem
    import weave_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic [ROW_IDX_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]     i_wdata,
    input  logic [ROW_IDX_W-1:0] i_raddr,
    output logic [WIDTH-1:0]     o_rdata
);

    logic [WIDTH-1:0] r_mem [ROWS];

    // Row storage: cleared by reset, at most one row written per cycle.
    always_ff @(posedge clk) begin
        // NOTE: the array is plain flops, so it is reset like any other state;
        // rows never loaded since reset play back as zero instead of X.
        if (rst) begin
            for (int i = 0; i < ROWS; i++) begin
                // NOTE: non-blocking so every flop samples pre-edge values.
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/weave_sequencer.sv
// weave_sequencer: command-programmed pattern player. Rows are loaded into
// a small memory, then played cyclically from row 0 to row 'last', each
// row held for max(period, 1) cycles.
module weave_sequencer
    import weave_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int WIDTH    = 8,
    parameter int PERIOD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [WIDTH-1:0]     cmd_data,
    output logic [WIDTH-1:0]     pat_out,
    output logic [2:0]           pat_row,
    output logic                 pat_valid,
    output logic                 row_tick
);

    localparam logic [ROW_IDX_W-1:0] ROW_MASK = ROW_IDX_W'(ROWS - 1);

    seq_state_e            r_state;
    logic [PERIOD_W-1:0]   r_period;
    logic [PERIOD_W-1:0]   r_cnt;
    logic [ROW_IDX_W-1:0]  r_last;
    logic [ROW_IDX_W-1:0]  r_wr_ptr;
    logic [ROW_IDX_W-1:0]  r_pat_row;
    logic [WIDTH-1:0]      r_pat_out;
    logic                  r_pat_valid;
    logic                  r_row_tick;
    logic                  r_cmd_ready;

    cmd_op_e               w_op;
    logic                  w_accept;
    logic                  w_we;
    logic [ROW_IDX_W-1:0]  w_rd_addr;
    logic [WIDTH-1:0]      w_rd_data;
    logic [PERIOD_W-1:0]   w_hold_m1;

    assign w_op     = cmd_op_e'(cmd_op);
    assign w_accept = cmd_valid & r_cmd_ready;
    assign w_we     = w_accept && (w_op == LOAD_ROW);

    // Read address of the row to show next, and the reload value for the
    // hold counter (a zero period behaves like a period of one).
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        w_rd_addr = '0;
        w_hold_m1 = '0;
        if (r_state == RUN) begin
            w_rd_addr = next_row(r_pat_row, r_last);
        end
        if (r_period != '0) begin
            w_hold_m1 = r_period - 1'b1;
        end
    end

    weave_row_mem #(
        .ROWS  (ROWS),
        .WIDTH (WIDTH)
    ) u_row_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (cmd_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    // Controller: command decode, playback state, hold counter and the
    // registered pattern outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_period    <= PERIOD_W'(1);
            r_last      <= ROW_MASK;
            r_wr_ptr    <= '0;
            r_cnt       <= '0;
            r_pat_out   <= '0;
            r_pat_row   <= '0;
            r_pat_valid <= 1'b0;
            r_row_tick  <= 1'b0;
            r_cmd_ready <= 1'b1;
        end else begin
            r_row_tick <= 1'b0;

            // Loads and period updates are accepted in any state that takes commands.
            if (w_we) begin
                r_wr_ptr <= (r_wr_ptr + 1'b1) & ROW_MASK;
            end
            if (w_accept && (w_op == SET_PERIOD)) begin
                r_period <= cmd_data[PERIOD_W-1:0];
            end

            unique case (r_state)
                IDLE: begin
                    // Outputs settle to zero one edge after a STOP.
                    r_pat_out   <= '0;
                    r_pat_row   <= '0;
                    r_pat_valid <= 1'b0;
                    r_cnt       <= '0;
                    if (w_accept && (w_op == START)) begin
                        r_last      <= cmd_data[ROW_IDX_W-1:0] & ROW_MASK;
                        r_state     <= PRIME;
                        r_cmd_ready <= 1'b0;
                    end
                end

                PRIME: begin
                    r_state     <= RUN;
                    r_cmd_ready <= 1'b1;
                    r_pat_out   <= w_rd_data;
                    r_pat_row   <= '0;
                    r_pat_valid <= 1'b1;
                    r_row_tick  <= 1'b1;
                    r_cnt       <= w_hold_m1;
                end

                RUN: begin
                    if (w_accept && (w_op == STOP)) begin
                        // Freeze the current row; IDLE clears outputs next edge.
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_pat_row  <= w_rd_addr;
                        r_pat_out  <= w_rd_data;
                        r_cnt      <= w_hold_m1;
                        r_row_tick <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign pat_out   = r_pat_out;
    assign pat_row   = r_pat_row;
    assign pat_valid = r_pat_valid;
    assign row_tick  = r_row_tick;

endmodule

// File: tb/tb_weave_sequencer.sv
// tb_weave_sequencer: scoreboard bench. Expected per-cycle outputs are pushed
// when stimulus is driven and popped/compared one cycle at a time.
module tb_weave_sequencer;
    import weave_pkg::*;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] pat_out;
    logic [2:0] pat_row;
    logic       pat_valid;
    logic       row_tick;

    typedef struct {
        logic [7:0] pat;
        logic [2:0] row;
        logic       valid;
        logic       tick;
        logic       ready;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] m_mem [8];
    int         n_checks = 0;
    int         n_errors = 0;

    weave_sequencer #(
        .ROWS     (8),
        .WIDTH    (8),
        .PERIOD_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .pat_out   (pat_out),
        .pat_row   (pat_row),
        .pat_valid (pat_valid),
        .row_tick  (row_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] pat, input logic [2:0] row,
                        input logic valid, input logic tick);
        exp_t e;
        e.pat   = pat;
        e.row   = row;
        e.valid = valid;
        e.tick  = tick;
        e.ready = 1'b1;
        sb_q.push_back(e);
    endtask

    // One playback row held for 'hold' cycles, tick on its first cycle.
    task automatic push_row(input int row, input int hold);
        for (int c = 0; c < hold; c++) begin
            push(m_mem[row], 3'(row), 1'b1, (c == 0));
        end
    endtask

    task automatic push_idle(input int n);
        for (int c = 0; c < n; c++) begin
            push(8'h00, 3'd0, 1'b0, 1'b0);
        end
    endtask

    // Advance one clock and compare the DUT against the next expected entry.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("pat_out",   pat_out,   e.pat);
            check("pat_row",   pat_row,   e.row);
            check("pat_valid", pat_valid, e.valid);
            check("row_tick",  row_tick,  e.tick);
            check("cmd_ready", cmd_ready, e.ready);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [7:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
    endtask

    task automatic idle_cmd();
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_data  = 8'h00;
    endtask

    // Present a command until accepted (bounded), return #1 after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [7:0] data);
        int n;
        drive(op, data);
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            check("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
        end
        @(posedge clk);
        #1;
        idle_cmd();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;

        // Reset held two cycles with a load presented: nothing may be taken.
        rst = 1'b1;
        drive(LOAD_ROW, 8'h55);
        repeat (2) @(posedge clk);
        #1;
        check("rst_pat_out",   pat_out,   32'h0);
        check("rst_pat_row",   pat_row,   32'h0);
        check("rst_pat_valid", pat_valid, 32'h0);
        check("rst_row_tick",  row_tick,  32'h0);
        check("rst_cmd_ready", cmd_ready, 32'h1);
        rst = 1'b0;
        idle_cmd();
        push_idle(2);
        repeat (2) step();

        // Full pattern, period 3, last row 7, then STOP on a row boundary.
        for (int i = 0; i < 8; i++) begin
            m_mem[i] = 8'(1 << i);
            send(LOAD_ROW, m_mem[i]);
        end
        send(SET_PERIOD, 8'd3);
        send(START, 8'd7);
        check("prime_cmd_ready", cmd_ready, 32'h0);
        check("prime_pat_valid", pat_valid, 32'h0);
        for (int r = 0; r < 8; r++) push_row(r, 3);
        push_row(0, 3);
        repeat (27) step();
        drive(STOP, 8'h00);
        push(m_mem[0], 3'd0, 1'b1, 1'b0);
        step();
        idle_cmd();
        push_idle(1);
        step();

        // Zero period, last row 2: one cycle per row, 0,1,2,0,...
        send(SET_PERIOD, 8'd0);
        send(START, 8'd2);
        for (int k = 0; k < 7; k++) push_row(k % 3, 1);
        repeat (7) step();
        drive(STOP, 8'h00);
        push(m_mem[0], 3'd0, 1'b1, 1'b0);
        step();
        idle_cmd();
        push_idle(1);
        step();

        // Live period change: 4 -> 2 during row 0; row 0 keeps 4 cycles.
        send(SET_PERIOD, 8'd4);
        send(START, 8'd7);
        push_row(0, 4);
        push_row(1, 2);
        push_row(2, 2);
        push_row(3, 2);
        step();
        drive(SET_PERIOD, 8'd2);
        step();
        idle_cmd();
        repeat (8) step();

        // Ninth load wraps to row 0 and shows on the next pass.
        drive(LOAD_ROW, 8'hAA);
        for (int r = 4; r < 8; r++) push_row(r, 2);
        step();
        idle_cmd();
        m_mem[0] = 8'hAA;
        push_row(0, 2);
        repeat (9) step();

        // Load into row 1 on the edge that advances into row 1: old value this pass.
        drive(LOAD_ROW, 8'h5A);
        push_row(1, 2);
        step();
        idle_cmd();
        m_mem[1] = 8'h5A;
        step();
        for (int r = 2; r < 8; r++) push_row(r, 2);
        push_row(0, 2);
        push(m_mem[1], 3'd1, 1'b1, 1'b1);
        repeat (15) step();

        // STOP mid-row: row frozen for the accepting edge, cleared after the next.
        drive(STOP, 8'h00);
        push(m_mem[1], 3'd1, 1'b1, 1'b0);
        step();
        idle_cmd();
        push_idle(1);
        step();

        // Restart from row 0 after PRIME.
        send(START, 8'd7);
        check("restart_prime_ready", cmd_ready, 32'h0);
        push_row(0, 2);
        push(m_mem[1], 3'd1, 1'b1, 1'b1);
        repeat (3) step();

        // Reset mid-run overrides a concurrent START.
        drive(START, 8'd3);
        rst = 1'b1;
        push_idle(1);
        step();
        rst = 1'b0;
        idle_cmd();
        push_idle(1);
        step();

        // After reset: memory cleared, period 1, last 7.
        for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
        send(START, 8'd7);
        push_row(0, 1);
        push_row(1, 1);
        push_row(2, 1);
        repeat (3) step();

        check("sb_drain", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/weave_sequencer.md
# weave_sequencer

Programmable pattern sequencer that drives the project's dedicated outputs. It stores up to eight 8-bit weave rows (warp-lift patterns) written through a command handshake, then plays them out cyclically with a programmable per-row hold period. It sits behind the project top: command fields are decoded from `ui_in`/`uio_in`, and `pat_out` feeds `uo_out`.

## Interface
- `ROWS`, 8: pattern depth. Power of two, at most 8.
- `WIDTH`, 8: pattern row width in bits.
- `PERIOD_W`, 8: width of the hold-period register.
- `clk` in 1: the single clock.
- `rst` in 1: reset. **Synchronous, active-high; one clock.**
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready` at a rising edge.
- `cmd_op` in 2: opcode, one of LOAD_ROW, SET_PERIOD, START, STOP.
- `cmd_data` in WIDTH: command payload.
- `pat_out` out WIDTH: current pattern row, registered.
- `pat_row` out 3: index of the row on `pat_out`.
- `pat_valid` out 1: high while playing.
- `row_tick` out 1: one-cycle pulse on every edge that loads a new row (including the first).

## Operation
- States:
  - IDLE: not playing.
  - PRIME: one cycle; `cmd_ready`=0.
  - RUN: playing.
- `cmd_ready` is 1 in IDLE and RUN, and 0 in PRIME. It never depends on `cmd_valid`.
- LOAD_ROW (00):
  - Writes `cmd_data` to `mem[wr_ptr]`; `wr_ptr` advances modulo ROWS.
  - Accepted in every state. A 9th load overwrites row 0.
- SET_PERIOD (01):
  - Sets `period` = `cmd_data[PERIOD_W-1:0]`. Effective hold = max(`period`, 1).
  - In RUN, the new value takes effect at the next row boundary.
- START (10):
  - Sets `last` = `cmd_data[2:0]` masked to ROWS-1; `wr_ptr` is unchanged.
  - IDLE → PRIME. Ignored in RUN.
- STOP (11):
  - RUN → IDLE; next edge `pat_out`=0, `pat_row`=0, `pat_valid`=0.
  - No effect in IDLE.
- PRIME → RUN, unconditionally, on the next edge:
  - `pat_out`=`mem[0]`, `pat_row`=0, `pat_valid`=1, `row_tick`=1.
  - `cnt` = hold−1.
- RUN, per cycle:
  - If `cnt`≠0: `cnt` decrements.
  - If `cnt`=0: advance. `pat_row` = (`pat_row`==`last`) ? 0 : `pat_row`+1; `pat_out`=`mem[new row]`; `cnt` = hold−1; `row_tick`=1.
- Same-edge LOAD_ROW to the row being advanced into: `pat_out` takes the old contents. The new value appears on the next pass.
- `rst` clears everything:
  - `mem`, `wr_ptr`, `cnt`, all outputs except `cmd_ready` → 0.
  - `period`=1, `last`=ROWS−1, state IDLE.
  - `cmd_ready`=1 from the first cycle after reset.
  - `rst` mid-run overrides any concurrent command.

## Timing
- Latency: START accepted at edge N → PRIME during cycle N..N+1 → first row on `pat_out` after edge N+1.
- Each row is held for exactly max(`period`, 1) cycles.
- Wrap is seamless: row `last` → row 0 with no gap cycle.
- STOP accepted at edge N → outputs clear after edge N+1. No partial row completes.
- Arithmetic:
  - `cnt` is PERIOD_W bits and never underflows.
  - Row and write pointers are 3 bits and wrap modulo ROWS.
  - `last` ≥ ROWS is impossible after masking.

## Structure
- Package `weave_pkg`:
  - `cmd_op_e`: LOAD_ROW=0, SET_PERIOD=1, START=2, STOP=3.
  - `seq_state_e`: IDLE, PRIME, RUN.
  - Constants: `ROWS_MAX`=8, `ROW_IDX_W`=3.
- One sub-module, `weave_row_mem`:
  - ROWS×WIDTH flop array; 1 write port, 1 combinational read port.
  - Synchronous reset to 0.
- The controller, counter and output registers live in `weave_sequencer`.

## Test plan
- **Reset:** hold `rst` 2 cycles with `cmd_valid`=1 → `pat_out`=0, `pat_valid`=0, `row_tick`=0, `cmd_ready`=1, no memory write.
- **Full pattern:** load 0x01,0x02,…,0x80; SET_PERIOD 3; START 7 → `pat_out`=0x01 from edge N+1 for 3 cycles, then 0x02, …, 0x80, then 0x01 again. `row_tick` every 3 cycles.
- **Short pattern, zero period:** SET_PERIOD 0; START 2 → 0x01,0x02,0x04,0x01,… changing every cycle; `pat_row` runs 0,1,2,0.
- **Live period update:** during RUN with period 4, SET_PERIOD 2 mid-row → current row still lasts 4 cycles; subsequent rows last 2.
- **Overwrite:**
  - 9th LOAD_ROW 0xAA → row 0 = 0xAA on the next pass.
  - LOAD_ROW on the advance edge into that row → old value shown this pass.
- **Stop and restart:**
  - STOP mid-row → outputs cleared after 1 edge.
  - START again → restarts at row 0 after PRIME.
  - `rst` asserted mid-run with a concurrent START → IDLE, all outputs 0.
